// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control unit: FSM states,
// opcode values, AluControl and AluSrcB encodings, and an opcode-legality helper.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    ALU_WB,
    MEM_ADR,
    MEM_RD,
    MEM_WB,
    MEM_WR,
    BRANCH,
    JAL
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // True for the opcodes this controller knows how to sequence.
  function automatic logic op_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU operation decoder: maps funct3 (plus funct7[5] for R-type) to AluControl.
// sltu shares the slt code and sra shares the srl code; this ALU has no
// separate unsigned-compare or arithmetic-shift operation.
module alu_decoder
  import ctrl_pkg::*;
#(
  parameter int ALUCTL_W = 3
) (
  input  logic [2:0]          funct3,
  input  logic                funct7_b5,
  input  logic                is_rtype,
  output logic [ALUCTL_W-1:0] alu_control
);

  // funct3 lookup; funct7[5] only distinguishes sub from add on R-type
  always_comb begin
    alu_control = ALU_ADD;
    case (funct3)
      3'b000:         alu_control = (is_rtype && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b001:         alu_control = ALU_SLL;
      3'b010, 3'b011: alu_control = ALU_SLT;
      3'b100:         alu_control = ALU_XOR;
      3'b101:         alu_control = ALU_SRL;
      3'b110:         alu_control = ALU_OR;
      default:        alu_control = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I datapath (fetch, decode, execute,
// memory, writeback). Outputs are decoded from the state register; IRWrite and
// PCWrite in FETCH and MemWrite in MEM_WR follow mem_ready so a stalled memory
// access never commits.
// Optional build macro MULTICYCLE_CTRL_PERF_EN adds the instret and stall_cnt
// performance counters; without it the FSM is unchanged and the ports are absent.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 7,
  parameter int ALUCTL_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                IorD,
  output logic                MemWrite,
  output logic                MtoR,
  output logic                IRWrite,
  output logic                AluSrcA,
  output logic [1:0]          AluSrcB,
  output logic                RegWrite,
  output logic                Branch,
  output logic                PCWrite,
  output logic                PCSel,
  output logic [ALUCTL_W-1:0] AluControl,
  output logic                illegal_op
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0]         instret,
  output logic [31:0]         stall_cnt
`endif
);

  state_t              state;
  logic [ALUCTL_W-1:0] alu_dec;

  // Only funct7[5] carries meaning for the supported instructions.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  alu_decoder #(
    .ALUCTL_W (ALUCTL_W)
  ) u_alu_decoder (
    .funct3      (funct3),
    .funct7_b5   (funct7[5]),
    .is_rtype    (state == EXEC_R),
    .alu_control (alu_dec)
  );

  // State register and transition rules; memory states hold until mem_ready
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:   if (mem_ready) state <= DECODE;
        DECODE: begin
          case (opcode)
            OP_R:               state <= EXEC_R;
            OP_I:               state <= EXEC_I;
            OP_LOAD, OP_STORE:  state <= MEM_ADR;
            OP_BRANCH:          state <= BRANCH;
            OP_JAL:             state <= JAL;
            default:            state <= FETCH;
          endcase
        end
        EXEC_R:  state <= ALU_WB;
        EXEC_I:  state <= ALU_WB;
        ALU_WB:  state <= FETCH;
        MEM_ADR: state <= opcode[5] ? MEM_WR : MEM_RD;
        MEM_RD:  if (mem_ready) state <= MEM_WB;
        MEM_WB:  state <= FETCH;
        MEM_WR:  if (mem_ready) state <= FETCH;
        BRANCH:  state <= FETCH;
        JAL:     state <= ALU_WB;
        default: state <= FETCH;
      endcase
    end
  end

  // Datapath controls decoded from state; commit strobes gated by mem_ready
  always_comb begin
    mem_req    = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    MtoR       = 1'b0;
    IRWrite    = 1'b0;
    AluSrcA    = 1'b0;
    AluSrcB    = SRCB_RS2;
    RegWrite   = 1'b0;
    Branch     = 1'b0;
    PCWrite    = 1'b0;
    PCSel      = 1'b0;
    AluControl = ALU_ADD;
    illegal_op = 1'b0;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        AluSrcB = SRCB_FOUR;
        // reset keeps the instruction/PC loads quiet even if memory is ready
        IRWrite = mem_ready & reset;
        PCWrite = mem_ready & reset;
      end
      DECODE: begin
        AluSrcB    = SRCB_IMM;
        illegal_op = ~op_legal(opcode[6:0]);
      end
      EXEC_R: begin
        AluSrcA    = 1'b1;
        AluSrcB    = SRCB_RS2;
        AluControl = alu_dec;
      end
      EXEC_I: begin
        AluSrcB    = SRCB_IMM;
        AluControl = alu_dec;
      end
      ALU_WB: begin
        RegWrite = 1'b1;
      end
      MEM_ADR: begin
        AluSrcA = 1'b1;
        AluSrcB = SRCB_IMM;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
      end
      MEM_WB: begin
        RegWrite = 1'b1;
        MtoR     = 1'b1;
      end
      MEM_WR: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemWrite = mem_ready;
      end
      BRANCH: begin
        AluSrcA    = 1'b1;
        AluSrcB    = SRCB_RS2;
        AluControl = ALU_SUB;
        Branch     = 1'b1;
        PCSel      = 1'b1;
      end
      JAL: begin
        PCWrite = 1'b1;
        PCSel   = 1'b1;
        AluSrcB = SRCB_FOUR;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic retire;

  // An instruction retires on the last cycle of every legal sequence
  assign retire = (state == ALU_WB) || (state == MEM_WB) || (state == BRANCH) ||
                  ((state == MEM_WR) && mem_ready);

  // Retired-instruction and memory-stall counters, free-running modulo 2^32
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret   <= '0;
      stall_cnt <= '0;
    end else begin
      if (retire) instret <= instret + 32'd1;
      if (mem_req && !mem_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
